// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
//   Sequences one timer_counter PWM instance for the elevator motor.
//   When run is requested it puts the timer in PWM mode and moves the duty
//   (compare) toward the requested target by at most STEP, once every
//   STEP_CYCLES clocks. When run is released it ramps the duty back to zero
//   and parks the timer in idle mode. estop forces idle with zero duty.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   run_req      1 = run at target_duty, 0 = ramp down and stop
//   target_duty  requested compare value, clamped to PERIOD+1 (100% duty)
//   estop        emergency stop, highest priority
//   control      timer mode: 2'b00 idle, 2'b10 PWM
//   max_count    timer period, constant PERIOD
//   compare      timer compare (duty)
//   busy         1 in any state other than IDLE
//   at_target    1 while in HOLD
//   state        debug: 0 IDLE, 1 RAMP, 2 HOLD, 3 STOP
module pwm_ramp_ctrl #(
    parameter logic [15:0] PERIOD      = 16'd999,
    parameter logic [15:0] STEP        = 16'd10,
    parameter logic [15:0] STEP_CYCLES = 16'd1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run_req,
    input  logic [15:0] target_duty,
    input  logic        estop,
    output logic [1:0]  control,
    output logic [15:0] max_count,
    output logic [15:0] compare,
    output logic        busy,
    output logic        at_target,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic [16:0] TGT_MAX = {1'b0, PERIOD} + 17'd1;
    localparam logic [16:0] STEP17  = {1'b0, STEP};
    localparam logic [1:0]  CTL_IDLE = 2'b00;
    localparam logic [1:0]  CTL_PWM  = 2'b10;

    state_t      state_q, state_d;
    logic [15:0] compare_q, compare_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  control_q;
    logic [15:0] max_count_q;
    logic        busy_q;
    logic        at_target_q;

    logic        tick;
    logic [16:0] tgt;
    logic [16:0] cmp17;
    logic [16:0] diff;
    logic [16:0] toward;
    logic [16:0] down;

    // Step arithmetic is done in 17 bits so PERIOD+1 and differences never wrap.
    always_comb begin
        cmp17 = {1'b0, compare_q};
        tgt   = ({1'b0, target_duty} > TGT_MAX) ? TGT_MAX : {1'b0, target_duty};
        tick  = ((state_q == RAMP) || (state_q == STOP)) &&
                (presc_q == (STEP_CYCLES - 16'd1));

        if (tgt > cmp17) begin
            diff   = tgt - cmp17;
            toward = cmp17 + ((diff < STEP17) ? diff : STEP17);
        end else begin
            diff   = cmp17 - tgt;
            toward = cmp17 - ((diff < STEP17) ? diff : STEP17);
        end

        down = cmp17 - ((cmp17 < STEP17) ? cmp17 : STEP17);
    end

    always_comb begin
        state_d   = state_q;
        compare_d = compare_q;

        case (state_q)
            IDLE: begin
                compare_d = '0;
                if (run_req) state_d = RAMP;
            end
            RAMP: begin
                if (!run_req) begin
                    state_d = STOP;
                end else if (tick) begin
                    compare_d = toward[15:0];
                    if (toward == tgt) state_d = HOLD;
                end else if (cmp17 == tgt) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!run_req)          state_d = STOP;
                else if (cmp17 != tgt) state_d = RAMP;
            end
            STOP: begin
                if (run_req) begin
                    state_d = RAMP;
                end else if (compare_q == '0) begin
                    state_d = IDLE;
                end else if (tick) begin
                    compare_d = down[15:0];
                    if (down == '0) state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                compare_d = '0;
            end
        endcase

        if (estop) begin
            state_d   = IDLE;
            compare_d = '0;
        end

        // Prescaler restarts on every state change so the first step after
        // entering RAMP or STOP lands a full STEP_CYCLES later.
        if ((state_d != state_q) || !((state_q == RAMP) || (state_q == STOP))) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            compare_q   <= '0;
            presc_q     <= '0;
            control_q   <= CTL_IDLE;
            max_count_q <= PERIOD;
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            compare_q   <= compare_d;
            presc_q     <= presc_d;
            control_q   <= (state_d == IDLE) ? CTL_IDLE : CTL_PWM;
            max_count_q <= PERIOD;
            busy_q      <= (state_d != IDLE);
            at_target_q <= (state_d == HOLD);
        end
    end

    assign control   = control_q;
    assign max_count = max_count_q;
    assign compare   = compare_q;
    assign busy      = busy_q;
    assign at_target = at_target_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed testbench for pwm_ramp_ctrl with PERIOD=99, STEP=10, STEP_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_pwm_ramp_ctrl;

    logic        clk;
    logic        reset_n;
    logic        run_req;
    logic [15:0] target_duty;
    logic        estop;
    logic [1:0]  control;
    logic [15:0] max_count;
    logic [15:0] compare;
    logic        busy;
    logic        at_target;
    logic [1:0]  state;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pwm_ramp_ctrl #(
        .PERIOD      (16'd99),
        .STEP        (16'd10),
        .STEP_CYCLES (16'd4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run_req     (run_req),
        .target_duty (target_duty),
        .estop       (estop),
        .control     (control),
        .max_count   (max_count),
        .compare     (compare),
        .busy        (busy),
        .at_target   (at_target),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One ramp step: compare holds for 3 clocks, then changes on the 4th.
    task automatic expect_step(input string tag, input int prev, input int next);
        repeat (3) cycle();
        check({tag, "_wait"}, 32'(compare), 32'(prev));
        cycle();
        check(tag, 32'(compare), 32'(next));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_control"},   32'(control),   32'd0);
        check({tag, "_compare"},   32'(compare),   32'd0);
        check({tag, "_max_count"}, 32'(max_count), 32'd99);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_at_target"}, 32'(at_target), 32'd0);
        check({tag, "_state"},     32'(state),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b1;
        run_req     = 1'b0;
        target_duty = 16'd0;
        estop       = 1'b0;

        // 1. reset asserted between edges
        #2 reset_n = 1'b0;
        #1 check_reset_vals("rst0");
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();
        check_reset_vals("idle");

        // 2. ramp up to 50
        run_req     = 1'b1;
        target_duty = 16'd50;
        cycle();
        check("up_state",   32'(state),   32'd1);
        check("up_control", 32'(control), 32'd2);
        check("up_busy",    32'(busy),    32'd1);
        check("up_cmp0",    32'(compare), 32'd0);
        for (int k = 1; k <= 5; k++) expect_step("up50", (k - 1) * 10, k * 10);
        check("up_hold_state", 32'(state),     32'd2);
        check("up_at_target",  32'(at_target), 32'd1);
        repeat (5) cycle();
        check("hold50_cmp",   32'(compare), 32'd50);
        check("hold50_state", 32'(state),   32'd2);

        // 3. clamp at PERIOD+1, then one small down-step
        target_duty = 16'd200;
        cycle();
        check("clamp_state", 32'(state),     32'd1);
        check("clamp_at",    32'(at_target), 32'd0);
        for (int k = 1; k <= 5; k++) expect_step("up100", 50 + (k - 1) * 10, 50 + k * 10);
        check("clamp_hold", 32'(state), 32'd2);
        repeat (4) cycle();
        check("clamp_cmp", 32'(compare), 32'd100);
        target_duty = 16'd95;
        cycle();
        check("dn95_state", 32'(state), 32'd1);
        expect_step("dn95", 100, 95);
        check("dn95_hold", 32'(state), 32'd2);

        // walk down to 30 to set up the stop cases
        target_duty = 16'd30;
        cycle();
        expect_step("dn85", 95, 85);
        for (int k = 1; k <= 5; k++) expect_step("dn", 85 - (k - 1) * 10, 85 - k * 10);
        expect_step("dn30", 35, 30);
        check("dn30_hold", 32'(state), 32'd2);

        // 4. soft stop from 30 to 0
        run_req = 1'b0;
        cycle();
        check("stop_state",   32'(state),   32'd3);
        check("stop_control", 32'(control), 32'd2);
        check("stop_busy",    32'(busy),    32'd1);
        expect_step("stop20", 30, 20);
        expect_step("stop10", 20, 10);
        expect_step("stop0", 10, 0);
        check("stop0_state",   32'(state),   32'd0);
        check("stop0_control", 32'(control), 32'd0);
        check("stop0_busy",    32'(busy),    32'd0);

        // 4b. ramp to 30, stop, resume at 10
        run_req = 1'b1;
        cycle();
        expect_step("r10", 0, 10);
        expect_step("r20", 10, 20);
        expect_step("r30", 20, 30);
        check("r30_hold", 32'(state), 32'd2);
        run_req = 1'b0;
        cycle();
        expect_step("s20", 30, 20);
        expect_step("s10", 20, 10);
        run_req = 1'b1;
        cycle();
        check("resume_state", 32'(state),   32'd1);
        check("resume_cmp",   32'(compare), 32'd10);
        expect_step("res20", 10, 20);
        expect_step("res30", 20, 30);
        check("res_hold", 32'(state), 32'd2);

        // 5. emergency stop during RAMP at 40
        target_duty = 16'd60;
        cycle();
        expect_step("e40", 30, 40);
        check("e40_state", 32'(state), 32'd1);
        estop = 1'b1;
        cycle();
        check("estop_cmp",     32'(compare), 32'd0);
        check("estop_control", 32'(control), 32'd0);
        check("estop_state",   32'(state),   32'd0);
        repeat (3) cycle();
        check("estop_stay", 32'(state), 32'd0);
        check("estop_busy", 32'(busy),  32'd0);
        estop = 1'b0;
        cycle();
        check("post_estop_state", 32'(state),   32'd1);
        check("post_estop_cmp",   32'(compare), 32'd0);
        expect_step("pe10", 0, 10);

        // 6a. zero target: IDLE -> RAMP -> HOLD at 0
        estop = 1'b1;
        cycle();
        estop   = 1'b0;
        run_req = 1'b0;
        cycle();
        check("z_idle", 32'(state), 32'd0);
        target_duty = 16'd0;
        run_req     = 1'b1;
        cycle();
        check("z_ramp", 32'(state), 32'd1);
        cycle();
        check("z_hold",    32'(state),     32'd2);
        check("z_at",      32'(at_target), 32'd1);
        check("z_cmp",     32'(compare),   32'd0);

        // 6b. run_req drops in the tick cycle: STOP, no up-step
        target_duty = 16'd20;
        cycle();
        check("t_ramp", 32'(state), 32'd1);
        repeat (3) cycle();
        run_req = 1'b0;
        cycle();
        check("t_stop_state", 32'(state),   32'd3);
        check("t_stop_cmp",   32'(compare), 32'd0);
        cycle();
        check("t_idle", 32'(state), 32'd0);

        // async reset from a busy state
        run_req = 1'b1;
        cycle();
        expect_step("ar10", 0, 10);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("rst1");
        cycle();
        reset_n = 1'b1;
        run_req = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
